// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: pipeline request/ack ports and SRAM pad signals of the SRAM arbiter
interface sram_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic              sram_wr_oe;
    logic [31:0]       sram_rdata;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [3:0]        sram_be_n;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
        input  sram_addr, sram_wdata, sram_wr_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack,
        output sram_addr, sram_wdata, sram_wr_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between IF and MEM ports; define SRAM_ARB_RR_EN for round-robin on contention
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          gnt_mem;
    logic          we_l;
    logic          any_req;
    logic          sel_mem;
    logic          we_nx;
    logic          ce_n_nx;
    logic          oe_n_nx;
    logic          we_n_nx;
    logic          wr_oe_nx;
    logic          if_ack_nx;
    logic          mem_ack_nx;
    logic          unused_bits;

    assign any_req     = bus.if_req | bus.mem_req;
    assign unused_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                           bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

`ifdef SRAM_ARB_RR_EN
    logic last_mem;
    assign sel_mem = bus.mem_req & (~bus.if_req | ~last_mem);
`else
    assign sel_mem = bus.mem_req;
`endif

    // state register plus latched request and registered SRAM/pipeline outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            gnt_mem        <= 1'b0;
            we_l           <= 1'b0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.sram_be_n  <= 4'hF;
            bus.sram_ce_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            bus.sram_we_n  <= 1'b1;
            bus.sram_wr_oe <= 1'b0;
            bus.if_ack     <= 1'b0;
            bus.mem_ack    <= 1'b0;
            bus.if_rdata   <= '0;
            bus.mem_rdata  <= '0;
`ifdef SRAM_ARB_RR_EN
            last_mem       <= 1'b0;
`endif
        end else begin
            state          <= state_nx;
            bus.sram_ce_n  <= ce_n_nx;
            bus.sram_oe_n  <= oe_n_nx;
            bus.sram_we_n  <= we_n_nx;
            bus.sram_wr_oe <= wr_oe_nx;
            bus.if_ack     <= if_ack_nx;
            bus.mem_ack    <= mem_ack_nx;
            cnt            <= state == SETUP ? CW'(WAIT_CYCLES) :
                              (state == STROBE && cnt != '0) ? cnt - 1'b1 : cnt;
            if (state == IDLE && any_req) begin
                gnt_mem        <= sel_mem;
                we_l           <= we_nx;
                bus.sram_addr  <= sel_mem ? bus.mem_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
                bus.sram_be_n  <= sel_mem ? ~bus.mem_be : 4'h0;
                bus.sram_wdata <= bus.mem_wdata;
`ifdef SRAM_ARB_RR_EN
                last_mem       <= sel_mem;
`endif
            end
            if (state == STROBE && cnt == '0 && !we_l) begin
                if (gnt_mem)
                    bus.mem_rdata <= bus.sram_rdata;
                else
                    bus.if_rdata  <= bus.sram_rdata;
            end
        end
    end

    // next state: fixed-timing walk through setup, strobe and hold
    always_comb begin
        case (state)
            IDLE:    state_nx = any_req ? SETUP : IDLE;
            SETUP:   state_nx = STROBE;
            STROBE:  state_nx = cnt == '0 ? DONE : STROBE;
            default: state_nx = IDLE;
        endcase
    end

    // next output values, derived from the state being entered so outputs stay registered
    always_comb begin
        we_nx      = state == IDLE ? sel_mem & bus.mem_we : we_l;
        ce_n_nx    = state_nx == IDLE;
        wr_oe_nx   = state_nx != IDLE && we_nx;
        oe_n_nx    = !(state_nx == STROBE && !we_nx);
        we_n_nx    = !(state_nx == STROBE && we_nx);
        if_ack_nx  = state_nx == DONE && !gnt_mem;
        mem_ack_nx = state_nx == DONE && gnt_mem;
    end
endmodule
